// File: rtl/fft_stream_framer_pkg.sv
// Shared FSM encoding and config-word field layout for the FFT stream framer.
package fft_stream_framer_pkg;

    typedef enum logic [1:0] {
        ST_CFG = 2'd0,
        ST_RUN = 2'd1,
        ST_PAD = 2'd2
    } state_t;

    localparam int CFG_FWD_BIT   = 0;
    localparam int CFG_SCALE_LSB = 1;

endpackage

// File: rtl/axis_sync_fifo.sv
// Registered FIFO: data visible one cycle after push. full/vld come from the
// registered occupancy, so a pop frees space for a push only on the next cycle.
module axis_sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         vld
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_ok;
    logic          rd_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign vld      = (count != '0);
    assign wr_ok    = push && !full;
    assign rd_ok    = pop && vld;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fft_stream_framer.sv
// Framing shell around the streaming FFT core: config on reset/request, input tlast
// and zero-pad on flush, buffered output with regenerated tlast, frame and tlast-error tracking.
module fft_stream_framer
    import fft_stream_framer_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter int                 LOG2_N    = 10,
    parameter int                 SCALE_W   = 10,
    parameter int                 CFG_W     = 16,
    parameter logic [SCALE_W-1:0] SCALE_DEF = 10'h2AB,
    parameter int                 OUT_DEPTH = 16
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               cfg_fwd,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic               cfg_update,
    input  logic               flush,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [CFG_W-1:0]   fft_cfg_tdata,
    output logic               fft_cfg_tvalid,
    input  logic               fft_cfg_tready,
    output logic [DATA_W-1:0]  fft_in_tdata,
    output logic               fft_in_tvalid,
    input  logic               fft_in_tready,
    output logic               fft_in_tlast,
    input  logic [DATA_W-1:0]  fft_out_tdata,
    input  logic               fft_out_tvalid,
    output logic               fft_out_tready,
    input  logic               fft_out_tlast,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [31:0]        frame_count,
    output logic               err_tlast
);
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    state_t             state;
    state_t             state_nxt;
    logic               cfg_fwd_q;
    logic [SCALE_W-1:0] cfg_scale_q;
    logic               pend;
    logic [LOG2_N-1:0]  in_cnt;
    logic [LOG2_N-1:0]  out_cnt;
    logic [LOG2_N-1:0]  in_cnt_hs;
    logic               blk;
    logic               run_hs;
    logic               in_hs;
    logic               cfg_hs;
    logic               out_hs;
    logic               out_last;
    logic               fifo_full;
    logic               fifo_vld;
    logic [DATA_W:0]    fifo_rd;

    // A pending config is only allowed to cut in on a frame boundary.
    assign blk       = pend && (in_cnt == '0);
    assign run_hs    = s_axis_tvalid && fft_in_tready && !blk;
    assign in_cnt_hs = in_cnt + LOG2_N'(run_hs);
    assign in_hs     = fft_in_tvalid && fft_in_tready;
    assign cfg_hs    = fft_cfg_tvalid && fft_cfg_tready;
    assign out_hs    = fft_out_tvalid && fft_out_tready;
    assign out_last  = (out_cnt == CNT_LAST);
    assign fft_in_tlast = (in_cnt == CNT_LAST);

    always_comb begin
        fft_cfg_tdata = '0;
        fft_cfg_tdata[CFG_FWD_BIT] = cfg_fwd_q;
        fft_cfg_tdata[CFG_SCALE_LSB +: SCALE_W] = cfg_scale_q;
    end

    always_comb begin
        state_nxt      = state;
        fft_cfg_tvalid = 1'b0;
        fft_in_tvalid  = 1'b0;
        fft_in_tdata   = '0;
        s_axis_tready  = 1'b0;
        if (!areset) begin
            case (state)
                ST_CFG: begin
                    fft_cfg_tvalid = 1'b1;
                    if (fft_cfg_tready) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    fft_in_tdata  = s_axis_tdata;
                    fft_in_tvalid = s_axis_tvalid && !blk;
                    s_axis_tready = fft_in_tready && !blk;
                    if (blk)                             state_nxt = ST_CFG;
                    else if (flush && in_cnt_hs != '0)   state_nxt = ST_PAD;
                end
                ST_PAD: begin
                    fft_in_tvalid = 1'b1;
                    if (fft_in_tready && in_cnt == CNT_LAST)
                        state_nxt = pend ? ST_CFG : ST_RUN;
                end
                default: state_nxt = ST_CFG;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= ST_CFG;
            cfg_fwd_q   <= 1'b1;
            cfg_scale_q <= SCALE_DEF;
            pend        <= 1'b0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            err_tlast   <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_nxt;
            // An update landing with the config handshake keeps pend so the newer word is resent.
            if (cfg_update) begin
                cfg_fwd_q   <= cfg_fwd;
                cfg_scale_q <= cfg_scale;
                pend        <= 1'b1;
            end else if (cfg_hs) begin
                pend <= 1'b0;
            end
            if (in_hs) in_cnt <= in_cnt + LOG2_N'(1);
            if (out_hs) begin
                out_cnt <= out_cnt + LOG2_N'(1);
                if (fft_out_tlast != out_last) err_tlast <= 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                frame_count <= frame_count + 32'd1;
        end
    end

    axis_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (out_hs),
        .push_data ({out_last, fft_out_tdata}),
        .full      (fifo_full),
        .pop       (m_axis_tvalid && m_axis_tready),
        .pop_data  (fifo_rd),
        .vld       (fifo_vld)
    );

    assign fft_out_tready = !fifo_full && !areset;
    assign m_axis_tvalid  = fifo_vld && !areset;
    assign m_axis_tdata   = fifo_rd[DATA_W-1:0];
    assign m_axis_tlast   = fifo_rd[DATA_W];

endmodule
